// File: rtl/data_case_router.sv
// data_case_router: first-match key dispatch of a valid/ready stream onto NUM branches plus a default, with saturating per-branch hit counters
module data_case_router #(
  parameter int DSIZE = 8,
  parameter int KSIZE = 8,
  parameter int NUM   = 4,
  parameter int ITEMS = 2,
  parameter int CSIZE = 16
) (
  input  logic                        clock,
  input  logic                        rst_n,
  input  logic [NUM*ITEMS*KSIZE-1:0]  match_table,
  input  logic [NUM*ITEMS-1:0]        match_en,
  input  logic                        s_valid,
  input  logic [DSIZE-1:0]            s_data,
  output logic                        s_ready,
  output logic [NUM:0]                m_valid,
  output logic [DSIZE-1:0]            m_data,
  input  logic [NUM:0]                m_ready,
  input  logic                        cnt_clr,
  output logic [(NUM+1)*CSIZE-1:0]    hit_cnt
);
  localparam int SW = $clog2(NUM + 1);
  logic [KSIZE-1:0] key;
  logic [NUM-1:0]   hit;
  logic [SW-1:0]    sel;
  logic [NUM:0]     onehot;
  logic             accept;
  logic             deliver;
  assign key     = s_data[KSIZE-1:0];
  assign deliver = |(m_valid & m_ready);
  assign s_ready = rst_n & (~|m_valid | deliver);
  assign accept  = s_valid & s_ready;
  assign onehot  = (NUM+1)'(1) << sel;
  // lowest matching branch wins; no hit falls through to the default branch
  always_comb begin
    hit = '0;
    for (int b = 0; b < NUM; b++)
      for (int i = 0; i < ITEMS; i++)
        if (match_en[b*ITEMS+i] && match_table[(b*ITEMS+i)*KSIZE +: KSIZE] == key) hit[b] = 1'b1;
    sel = SW'(NUM);
    for (int b = NUM - 1; b >= 0; b--)
      if (hit[b]) sel = SW'(b);
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      m_valid <= '0;
      m_data  <= '0;
    end else if (accept) begin
      m_valid <= onehot;
      m_data  <= s_data;
    end else if (deliver) m_valid <= '0;
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) hit_cnt <= '0;
    else
      for (int b = 0; b <= NUM; b++)
        if (cnt_clr) hit_cnt[b*CSIZE +: CSIZE] <= '0;
        else if (m_valid[b] && m_ready[b] && !(&hit_cnt[b*CSIZE +: CSIZE]))
          hit_cnt[b*CSIZE +: CSIZE] <= hit_cnt[b*CSIZE +: CSIZE] + CSIZE'(1);
endmodule

// File: tb/tb_data_case_router.sv
// tb_data_case_router: directed scenario tasks with hand-computed expectations
module tb_data_case_router;
  localparam int DSIZE = 8, KSIZE = 8, NUM = 4, ITEMS = 2, CSIZE = 4;
  logic                       clock = 0;
  logic                       rst_n = 0;
  logic [NUM*ITEMS*KSIZE-1:0] match_table;
  logic [NUM*ITEMS-1:0]       match_en;
  logic                       s_valid = 0;
  logic [DSIZE-1:0]           s_data = '0;
  logic                       s_ready;
  logic [NUM:0]               m_valid;
  logic [DSIZE-1:0]           m_data;
  logic [NUM:0]               m_ready = '1;
  logic                       cnt_clr = 0;
  logic [(NUM+1)*CSIZE-1:0]   hit_cnt;
  int compared = 0, mismatched = 0;

  data_case_router #(.DSIZE(DSIZE), .KSIZE(KSIZE), .NUM(NUM), .ITEMS(ITEMS), .CSIZE(CSIZE)) dut (
    .clock(clock), .rst_n(rst_n), .match_table(match_table), .match_en(match_en),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt));

  always #5 clock = ~clock;

  function automatic logic [CSIZE-1:0] cnt(input int b);
    return hit_cnt[b*CSIZE +: CSIZE];
  endfunction

  task automatic set_item(input int b, input int i, input logic [7:0] k, input logic en);
    match_table[(b*ITEMS+i)*KSIZE +: KSIZE] = k;
    match_en[b*ITEMS+i] = en;
  endtask

  task automatic load_table();
    set_item(0, 0, 8'h10, 1); set_item(0, 1, 8'h11, 1);
    set_item(1, 0, 8'h20, 1); set_item(1, 1, 8'h21, 1);
    set_item(2, 0, 8'h30, 1); set_item(2, 1, 8'h31, 1);
    set_item(3, 0, 8'h40, 1); set_item(3, 1, 8'h41, 1);
  endtask

  task automatic test_reset();
    #2;
    compared++; if (m_valid !== 5'b0 || m_data !== 8'h00) begin mismatched++; $display("FAIL reset_out: m_valid=%b m_data=%h, want 00000/00", m_valid, m_data); end
    compared++; if (s_ready !== 1'b0) begin mismatched++; $display("FAIL reset_sready: got %b want 0", s_ready); end
    compared++; if (hit_cnt !== '0) begin mismatched++; $display("FAIL reset_cnt: got %h want 0", hit_cnt); end
    @(negedge clock); rst_n = 1; #1;
    compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL release_sready: got %b want 1", s_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] keys [4] = '{8'h21, 8'h10, 8'h31, 8'h41};
    logic [4:0] exp  [4] = '{5'b00010, 5'b00001, 5'b00100, 5'b01000};
    int         br   [4] = '{1, 0, 2, 3};
    m_ready = '1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock); s_valid = 1; s_data = keys[k];
      @(negedge clock); s_valid = 0;
      compared++; if (m_valid !== exp[k] || m_data !== keys[k]) begin mismatched++; $display("FAIL basic_route key=%h: m_valid=%b m_data=%h, want %b/%h", keys[k], m_valid, m_data, exp[k], keys[k]); end
      @(negedge clock);
      compared++; if (cnt(br[k]) !== 4'd1 || m_valid !== 5'b0) begin mismatched++; $display("FAIL basic_cnt b%0d: cnt=%0d m_valid=%b, want 1/00000", br[k], cnt(br[k]), m_valid); end
    end
  endtask

  task automatic test_overlap();
    set_item(1, 0, 8'h55, 1); set_item(3, 1, 8'h55, 1);
    @(negedge clock); s_valid = 1; s_data = 8'h55;
    @(negedge clock); s_valid = 0;
    compared++; if (m_valid !== 5'b00010) begin mismatched++; $display("FAIL overlap_first: got %b want 00010", m_valid); end
    set_item(1, 0, 8'h55, 0);
    @(negedge clock); s_valid = 1; s_data = 8'h55;
    @(negedge clock); s_valid = 0;
    compared++; if (m_valid !== 5'b01000) begin mismatched++; $display("FAIL overlap_disabled: got %b want 01000", m_valid); end
    @(negedge clock);
    compared++; if (cnt(1) !== 4'd2 || cnt(3) !== 4'd2) begin mismatched++; $display("FAIL overlap_cnt: b1=%0d b3=%0d, want 2/2", cnt(1), cnt(3)); end
    load_table();
  endtask

  task automatic test_default();
    m_ready = 5'b01111;
    @(negedge clock); s_valid = 1; s_data = 8'h99;
    @(negedge clock); s_data = 8'h10;
    compared++; if (m_valid !== 5'b10000 || m_data !== 8'h99) begin mismatched++; $display("FAIL default_route: m_valid=%b m_data=%h, want 10000/99", m_valid, m_data); end
    set_item(0, 1, 8'h99, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      compared++; if (m_valid !== 5'b10000 || m_data !== 8'h99 || s_ready !== 1'b0) begin mismatched++; $display("FAIL default_hold c%0d: m_valid=%b m_data=%h s_ready=%b, want 10000/99/0", c, m_valid, m_data, s_ready); end
    end
    m_ready = '1; #1;
    compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL default_release_sready: got %b want 1", s_ready); end
    @(negedge clock); s_valid = 0;
    compared++; if (cnt(4) !== 4'd1 || m_valid !== 5'b00001 || m_data !== 8'h10) begin mismatched++; $display("FAIL default_release: cnt4=%0d m_valid=%b m_data=%h, want 1/00001/10", cnt(4), m_valid, m_data); end
    @(negedge clock);
    compared++; if (cnt(0) !== 4'd2 || m_valid !== 5'b0) begin mismatched++; $display("FAIL default_next_cnt: cnt0=%0d m_valid=%b, want 2/00000", cnt(0), m_valid); end
    load_table();
  endtask

  task automatic test_back_to_back();
    logic [7:0] prev;
    @(negedge clock); cnt_clr = 1;
    @(negedge clock); cnt_clr = 0;
    compared++; if (hit_cnt !== '0) begin mismatched++; $display("FAIL clear_all: got %h want 0", hit_cnt); end
    prev = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        compared++; if (m_data !== prev || m_valid !== (prev == 8'h10 ? 5'b00001 : 5'b00100)) begin mismatched++; $display("FAIL b2b_out beat%0d: m_valid=%b m_data=%h, want data %h", i - 1, m_valid, m_data, prev); end
      end
      compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_sready beat%0d: got %b want 1", i, s_ready); end
      s_valid = 1; s_data = (i % 2 == 0) ? 8'h10 : 8'h30; prev = s_data;
      @(negedge clock);
    end
    s_valid = 0;
    compared++; if (m_data !== 8'h30 || m_valid !== 5'b00100) begin mismatched++; $display("FAIL b2b_last: m_valid=%b m_data=%h, want 00100/30", m_valid, m_data); end
    @(negedge clock);
    compared++; if (cnt(0) !== 4'd8 || cnt(2) !== 4'd8) begin mismatched++; $display("FAIL b2b_cnt: b0=%0d b2=%0d, want 8/8", cnt(0), cnt(2)); end
  endtask

  task automatic test_saturation();
    @(negedge clock); cnt_clr = 1;
    @(negedge clock); cnt_clr = 0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1; s_data = 8'h10;
      @(negedge clock);
    end
    s_valid = 0;
    @(negedge clock);
    compared++; if (cnt(0) !== 4'd15) begin mismatched++; $display("FAIL saturate: got %0d want 15", cnt(0)); end
    s_valid = 1; s_data = 8'h11;
    @(negedge clock); s_valid = 0;
    compared++; if (m_valid !== 5'b00001 || cnt(0) !== 4'd15) begin mismatched++; $display("FAIL saturate_hold: m_valid=%b cnt0=%0d, want 00001/15", m_valid, cnt(0)); end
    cnt_clr = 1;
    @(negedge clock); cnt_clr = 0;
    compared++; if (cnt(0) !== 4'd0 || m_valid !== 5'b0) begin mismatched++; $display("FAIL clear_wins: cnt0=%0d m_valid=%b, want 0/00000", cnt(0), m_valid); end
  endtask

  task automatic test_reset_mid();
    m_ready = '0;
    @(negedge clock); s_valid = 1; s_data = 8'h30;
    @(negedge clock); s_valid = 0;
    compared++; if (m_valid !== 5'b00100 || m_data !== 8'h30) begin mismatched++; $display("FAIL mid_held: m_valid=%b m_data=%h, want 00100/30", m_valid, m_data); end
    #2 rst_n = 0; #1;
    compared++; if (m_valid !== 5'b0 || m_data !== 8'h00 || s_ready !== 1'b0) begin mismatched++; $display("FAIL mid_async: m_valid=%b m_data=%h s_ready=%b, want 00000/00/0", m_valid, m_data, s_ready); end
    @(negedge clock); rst_n = 1; m_ready = '1;
    @(negedge clock); s_valid = 1; s_data = 8'h41;
    @(negedge clock); s_valid = 0;
    compared++; if (m_valid !== 5'b01000 || m_data !== 8'h41) begin mismatched++; $display("FAIL mid_after: m_valid=%b m_data=%h, want 01000/41", m_valid, m_data); end
    @(negedge clock);
    compared++; if (cnt(3) !== 4'd1) begin mismatched++; $display("FAIL mid_cnt: got %0d want 1", cnt(3)); end
  endtask

  initial begin
    match_table = '0; match_en = '0;
    load_table();
    test_reset();
    test_basic();
    test_overlap();
    test_default();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/data_case_router.md
Name: data_case_router

Overview:
- Streaming case-dispatch block: compares a key field of each incoming valid/ready beat against a runtime match table, then forwards the beat to exactly one of NUM branch outputs, or to a default output.
- Parametrised, registered successor to the single-process case construct: configurable branch count, items per branch, key and data widths.
- Adds per-output hit counters.
- Sits between a stream source and NUM+1 downstream consumers in data_inf_c-style stream fabrics.

Parameters:
- DSIZE, 8, beat data width.
- KSIZE, 8, key width; key = s_data[KSIZE-1:0]; KSIZE <= DSIZE.
- NUM, 4, number of matched branches (1..16); output index NUM is the default branch.
- ITEMS, 2, match items per branch (1..8), like comma-separated case items.
- CSIZE, 16, hit counter width.

Ports:
- clock  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- match_table  input  NUM*ITEMS*KSIZE  item (b,i) at bits [(b*ITEMS+i)*KSIZE +: KSIZE]; quasi-static.
- match_en  input  NUM*ITEMS  bit b*ITEMS+i enables item (b,i).
- s_valid  input  1  upstream beat valid.
- s_data  input  DSIZE  upstream beat.
- s_ready  output  1  upstream ready.
- m_valid  output  NUM+1  one-hot branch valid; bit NUM is default.
- m_data  output  DSIZE  registered beat, shared by all branches.
- m_ready  input  NUM+1  per-branch ready.
- cnt_clr  input  1  synchronous clear of all hit counters.
- hit_cnt  output  (NUM+1)*CSIZE  per-branch delivered-beat count, saturating.

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_data=0, internal sel=0, all hit_cnt=0.
- s_ready = 0 during reset; after reset s_ready = ~|m_valid | (|(m_valid & m_ready)).
- Match decode (combinational, on s_data):
  - Item (b,i) hits when match_en[b*ITEMS+i]=1 and key equals its table entry.
  - Winner is the lowest b with any hit (case first-match semantics); item order within a branch is irrelevant.
  - No hit selects branch NUM.
  - Disabled items never match, even when the table entry equals the key.
- Accept when s_valid & s_ready. On the next edge: m_data <= s_data, m_valid <= one-hot(sel). Latency exactly 1 cycle.
- Output register holds m_data/m_valid stable until the selected m_ready is high. Readies of unselected branches are ignored.
- Simultaneous output handshake and new accept: the new beat is loaded in the same cycle, giving full throughput of 1 beat/cycle when the selected branch keeps ready high.
- match_table and match_en are sampled only at accept. Changes take effect on the next accepted beat; a held beat is never re-routed.
- Counters:
  - hit_cnt[b] increments by 1 on m_valid[b] & m_ready[b].
  - Saturates at 2^CSIZE-1 (no wrap).
  - cnt_clr=1 forces all counters to 0 that cycle. Clear wins over a same-cycle increment; that beat is not counted.
- Reset mid-transfer: a held beat is discarded, counters zero, no partial output.
- Invariant: m_valid is one-hot or zero, never multi-hot.

Test Plan:
- NUM=4, ITEMS=2, table b0={0x10,0x11}, b1={0x20,0x21}, b2={0x30,0x31}, b3={0x40,0x41}, all enabled; send 0x21 with all ready → m_valid=5'b00010 one cycle later, m_data=0x21, hit_cnt[1]=1.
- Overlap: b1 item0=0x55 and b3 item1=0x55; send 0x55 → b1 wins, m_valid=5'b00010; then disable b1 item0 and send 0x55 → m_valid=5'b01000.
- Default: send 0x99 (no match) → m_valid=5'b10000; hold m_ready[4]=0 for 3 cycles → m_data stable, s_ready=0, m_ready[0..3]=1 ignored; release → hit_cnt[4]=1.
- Throughput: 16 back-to-back beats alternating 0x10/0x30, all ready=1 → s_ready constantly 1, one output per cycle, hit_cnt[0]=8, hit_cnt[2]=8.
- Saturation/clear: CSIZE=4; route 20 beats to b0 → hit_cnt[0]=15; assert cnt_clr in the same cycle as a b0 handshake → hit_cnt[0]=0 next cycle.
- Reset mid-operation: beat held with m_ready=0, pulse rst_n low asynchronously between edges → m_valid=0, m_data=0 immediately; after release the first new beat routes normally.
